// File: rtl/bytewise_sdp_ram.sv
// Simple-dual-port RAM with byte strobes, per-entry valid bits,
// write-first read merge and 1- or 2-cycle read latency.
module bytewise_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NBYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NBYTES-1:0]     wr_strb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_hit
);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
        $error("LATENCY must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  we;
    logic                  wr_keep;
    logic                  same;
    logic                  old_ok;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_hit_c;

    assign wr_ok   = {1'b0, wr_addr} < DEPTH_W;
    assign rd_ok   = {1'b0, rd_addr} < DEPTH_W;
    assign wr_idx  = wr_ok ? wr_addr : '0;
    assign rd_idx  = rd_ok ? rd_addr : '0;
    assign we      = wr_en & (|wr_strb) & wr_ok;
    // Old lanes survive only in an entry that is valid and not being cleared
    assign wr_keep = valid[wr_idx] & ~clear;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end else if (!wr_keep) begin
                    mem[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
        end else begin
            if (clear) valid <= '0;
            if (we)    valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_old   = mem[rd_idx];
    assign same     = we & rd_ok & (wr_idx == rd_idx);
    assign old_ok   = rd_ok & valid[rd_idx] & ~clear;
    assign rd_hit_c = same | old_ok;

    // Entry state as it will be after this edge's clear/write
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (same && wr_strb[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (old_ok) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    rd_old[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic                  s_v;
    logic [DATA_WIDTH-1:0] s_d;
    logic                  s_h;

    if (LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                s_v <= 1'b0;
                s_d <= '0;
                s_h <= 1'b0;
            end else begin
                s_v <= rd_en;
                if (rd_en) begin
                    s_d <= rd_word;
                    s_h <= rd_hit_c;
                end
            end
        end
    end else begin : g_lat1
        assign s_v = rd_en;
        assign s_d = rd_word;
        assign s_h = rd_hit_c;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_hit   <= 1'b0;
        end else begin
            rd_valid <= s_v;
            if (s_v) begin
                rd_data <= s_d;
                rd_hit  <= s_h;
            end
        end
    end

endmodule

// File: tb/tb_bytewise_sdp_ram.sv
// Randomised scoreboard bench for bytewise_sdp_ram, run at
// LATENCY 1 and 2 side by side on a non-power-of-two depth.
module tb_bytewise_sdp_ram;

    localparam int DW = 32;
    localparam int D  = 12;
    localparam int AW = 4;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NB-1:0] wr_strb = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clear = 1'b0;

    logic [DW-1:0] d1, d2;
    logic          v1, v2, h1, h2;

    bytewise_sdp_ram #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(D),
                       .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .clear(clear), .rd_data(d1),
        .rd_valid(v1), .rd_hit(h1)
    );

    bytewise_sdp_ram #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(D),
                       .LATENCY(2)) dut2 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data), .rd_en(rd_en),
        .rd_addr(rd_addr), .clear(clear), .rd_data(d2),
        .rd_valid(v2), .rd_hit(h2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          h;
        int            c;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [DW-1:0] m_mem [16];
    bit            m_vld [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_out(input string nm, input logic v,
                             input logic [DW-1:0] d, input logic h,
                             ref exp_t q[$], ref logic [DW-1:0] last);
        exp_t e;
        if (!resetn) begin
            last = '0;
        end else if (v) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL %s unexpected result: got d=%h h=%0b at cyc %0d",
                         nm, d, h, cyc);
            end else begin
                e = q.pop_front();
                if (d !== e.d || h !== e.h || cyc != e.c) begin
                    bad++;
                    $display("FAIL %s read: got d=%h h=%0b cyc=%0d want d=%h h=%0b cyc=%0d",
                             nm, d, h, cyc, e.d, e.h, e.c);
                end
            end
            last = d;
        end else begin
            total++;
            if (d !== last) begin
                bad++;
                $display("FAIL %s hold: got d=%h want d=%h", nm, d, last);
            end
        end
    endtask

    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    always @(posedge clk) begin
        #1;
        check_out("lat1", v1, d1, h1, q1, last1);
        check_out("lat2", v2, d2, h2, q2, last2);
    end

    task automatic step(input logic we, input int wa, input logic [NB-1:0] ws,
                        input logic [DW-1:0] wd, input logic re, input int ra,
                        input logic clr);
        logic [DW-1:0] nw;
        exp_t e;
        @(negedge clk);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_strb = ws;
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        clear   = clr;
        nw = (m_vld[wa] && !clr) ? m_mem[wa] : '0;
        for (int b = 0; b < NB; b++)
            if (ws[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
        if (clr)
            for (int i = 0; i < 16; i++) m_vld[i] = 0;
        if (we && ws != 0 && wa < D) begin
            m_mem[wa] = nw;
            m_vld[wa] = 1;
        end
        if (re) begin
            e.h = (ra < D) && m_vld[ra];
            e.d = e.h ? m_mem[ra] : '0;
            e.c = cyc + 1;
            q1.push_back(e);
            e.c = cyc + 2;
            q2.push_back(e);
        end
    endtask

    task automatic wr(input int a, input logic [NB-1:0] s,
                      input logic [DW-1:0] d);
        step(1, a, s, d, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, '0, '0, 1, a, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 0;
        end
        #12;
        total++;
        if (v1 !== 1'b0 || d1 !== '0 || h1 !== 1'b0 ||
            v2 !== 1'b0 || d2 !== '0 || h2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got v=%0b%0b d=%h/%h h=%0b%0b want zeros",
                     v1, v2, d1, d2, h1, h2);
        end
        @(negedge clk);
        resetn = 1'b1;

        rd(5);
        wr(3, 4'b1111, 32'hDEADBEEF);
        rd(3);
        wr(3, 4'b0010, 32'h00001200);
        rd(3);
        wr(7, 4'b0001, 32'h000000AA);
        rd(7);
        wr(4, 4'b1111, 32'h11223344);
        step(1, 4, 4'b1100, 32'hAABB0000, 1, 4, 0);
        rd(4);
        for (int a = 0; a < 4; a++) wr(a, 4'b1111, 32'h1000 + a);
        step(1, 2, 4'b1111, 32'h00000055, 0, 0, 1);
        for (int a = 0; a < 4; a++) rd(a);
        wr(1, 4'b1111, 32'hCAFEF00D);
        step(1, 1, 4'b0000, 32'h12345678, 1, 1, 0);
        step(0, 0, '0, '0, 1, 1, 1);
        wr(13, 4'b1111, 32'h0BADBEEF);
        rd(13);
        wr(11, 4'b0101, 32'h77665544);
        rd(11);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            int wa, ra;
            wa = $urandom_range(15);
            ra = ($urandom_range(2) == 0) ? wa : $urandom_range(15);
            step($urandom_range(1), wa, NB'($urandom_range(15)), $urandom,
                 $urandom_range(3) != 0, ra, $urandom_range(39) == 0);
        end
        idle(3);

        for (int a = 0; a < 4; a++) wr(a, 4'b1111, 32'hA0 + a);
        for (int a = 0; a < 4; a++) rd(a);
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        clear = 0;
        resetn = 1'b0;
        for (int i = 0; i < 16; i++) m_vld[i] = 0;
        q1.delete();
        q2.delete();
        #1;
        total++;
        if (v2 !== 1'b0 || d2 !== '0 || v1 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got v1=%0b v2=%0b d2=%h want 0 0 0",
                     v1, v2, d2);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle(4);
        rd(2);
        idle(4);

        total++;
        if (q1.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending want 0/0",
                     q1.size(), q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
